lnspipe_interlock: RTL and testbench

Issue-control scheduler for the 3-stage LNS pipeline. It sits between stage 1 (fetch/decode) and stage 2 (register read/write). A per-register scoreboard detects RAW and WAW hazards on the shared register file, plus hazards on the condition latch. On a hazard it stalls fetch and injects bubbles. It squashes wrong-path instructions after a taken br/jr, and drains the pipeline before halt.

---
 rtl/lnspipe_interlock.sv | 158 +++++++++++++++
 tb/tb_lnspipe_interlock.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lnspipe_interlock.sv
// Issue interlock between fetch/decode and register read for the LNS pipeline.
// Scoreboards register and condition-latch writes, squashes redirects, drains on halt.
module lnspipe_interlock #(
    parameter int NREGS        = 16,
    parameter int REGW         = 4,
    parameter int SQUASH_SLOTS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REGW-1:0]  id_srcs,
    input  logic             id_uses_s,
    input  logic [REGW-1:0]  id_srct,
    input  logic             id_uses_t,
    input  logic [REGW-1:0]  id_dest,
    input  logic             id_writes,
    input  logic [1:0]       id_lat,
    input  logic             id_cond_rd,
    input  logic             id_cond_wr,
    input  logic             redirect,
    input  logic             drain_req,
    output logic             issue,
    output logic             stall,
    output logic             bubble,
    output logic             squash,
    output logic [NREGS-1:0] busy_map,
    output logic             drain_done
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] SQUASH  = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] HALTED  = 2'd3;
    localparam logic [1:0] SQ_LOAD = 2'(SQUASH_SLOTS);

    logic [1:0]       r_state;
    logic [1:0]       r_cnt [NREGS];
    logic             r_cond;
    logic [1:0]       r_sq;

    logic [1:0]       w_state_nx;
    logic [1:0]       w_sq_nx;
    logic [NREGS-1:0] w_busy;
    logic             w_drained;
    logic             w_raw;
    logic             w_waw;
    logic             w_ch;
    logic             w_haz;
    logic [1:0]       w_lat;
    logic             w_issue;
    logic             w_stall;
    logic             w_bubble;
    logic             w_squash;

    // w_drained looks at post-decrement counts so HALTED is entered
    // on the same edge that the last pending write commits.
    always_comb begin
        w_busy    = '0;
        w_drained = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            w_busy[i] = (r_cnt[i] != 2'd0);
            if (r_cnt[i] > 2'd1)
                w_drained = 1'b0;
        end
    end

    assign w_raw = (id_uses_s & w_busy[id_srcs])
                 | (id_uses_t & w_busy[id_srct]);
    assign w_waw = id_writes & w_busy[id_dest];
    assign w_ch  = id_cond_rd & r_cond;
    assign w_haz = id_valid & (w_raw | w_waw | w_ch);
    assign w_lat = (id_lat == 2'd0) ? 2'd1 : id_lat;

    always_comb begin
        w_issue    = 1'b0;
        w_stall    = 1'b0;
        w_bubble   = 1'b0;
        w_squash   = 1'b0;
        w_state_nx = r_state;
        w_sq_nx    = r_sq;
        case (r_state)
            RUN: begin
                if (redirect) begin
                    w_squash   = 1'b1;
                    w_sq_nx    = SQ_LOAD;
                    w_state_nx = (SQ_LOAD != 2'd0) ? SQUASH : RUN;
                end else if (drain_req) begin
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                    w_state_nx = DRAIN;
                end else if (w_haz) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else begin
                    w_issue = id_valid;
                end
            end
            SQUASH: begin
                w_squash = 1'b1;
                if (redirect) begin
                    w_sq_nx = SQ_LOAD;
                end else if (r_sq <= 2'd1) begin
                    w_sq_nx    = 2'd0;
                    w_state_nx = RUN;
                end else begin
                    w_sq_nx = r_sq - 2'd1;
                end
            end
            DRAIN: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (w_drained)
                    w_state_nx = HALTED;
            end
            HALTED: begin
                w_stall = 1'b1;
            end
            default: begin
                w_state_nx = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_sq    <= 2'd0;
            r_cond  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sq    <= w_sq_nx;
            r_cond  <= w_issue & id_cond_wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_issue && id_writes && id_dest == REGW'(i))
                    r_cnt[i] <= w_lat;
                else if (r_cnt[i] != 2'd0)
                    r_cnt[i] <= r_cnt[i] - 2'd1;
            end
        end
    end

    // Gate with reset so a mid-cycle reset drops the controls at once.
    assign issue      = w_issue  & ~reset;
    assign stall      = w_stall  & ~reset;
    assign bubble     = w_bubble & ~reset;
    assign squash     = w_squash & ~reset;
    assign drain_done = (r_state == HALTED) & ~reset;
    assign busy_map   = w_busy;

endmodule

// File: tb/tb_lnspipe_interlock.sv
// Randomized + directed bench for lnspipe_interlock against a cycle-time model.
// The model tracks the cycle at which each register becomes free.
module tb_lnspipe_interlock;

    localparam int NR    = 16;
    localparam int SLOTS = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [3:0]    id_srcs;
    logic          id_uses_s;
    logic [3:0]    id_srct;
    logic          id_uses_t;
    logic [3:0]    id_dest;
    logic          id_writes;
    logic [1:0]    id_lat;
    logic          id_cond_rd;
    logic          id_cond_wr;
    logic          redirect;
    logic          drain_req;
    logic          issue;
    logic          stall;
    logic          bubble;
    logic          squash;
    logic [NR-1:0] busy_map;
    logic          drain_done;

    always #5 clk = ~clk;

    lnspipe_interlock #(
        .NREGS(NR), .REGW(4), .SQUASH_SLOTS(SLOTS)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid),
        .id_srcs(id_srcs), .id_uses_s(id_uses_s),
        .id_srct(id_srct), .id_uses_t(id_uses_t),
        .id_dest(id_dest), .id_writes(id_writes),
        .id_lat(id_lat),
        .id_cond_rd(id_cond_rd), .id_cond_wr(id_cond_wr),
        .redirect(redirect), .drain_req(drain_req),
        .issue(issue), .stall(stall), .bubble(bubble),
        .squash(squash), .busy_map(busy_map),
        .drain_done(drain_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: first cycle at which each resource is free again.
    int t = 0;
    int reg_free [NR];
    int cond_free = 0;
    int sq_end = 0;
    bit draining = 1'b0;
    int halt_at = 0;

    logic          e_iss, e_st, e_bub, e_sq, e_dd;
    logic [NR-1:0] e_bm;
    bit            m_haz;
    int            m_lat;

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%b want=%b", nm, t, got, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [NR-1:0] got,
                        input logic [NR-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, got, exp);
        end
    endtask

    function automatic bit busy(input logic [3:0] r);
        return t < reg_free[r];
    endfunction

    always @(negedge clk) begin
        e_iss = 1'b0; e_st = 1'b0; e_bub = 1'b0;
        e_sq = 1'b0;  e_dd = 1'b0; e_bm = '0;
        if (reset) begin
            for (int r = 0; r < NR; r++) reg_free[r] = 0;
            cond_free = 0;
            sq_end    = 0;
            draining  = 1'b0;
            halt_at   = 0;
        end else begin
            for (int r = 0; r < NR; r++) e_bm[r] = (t < reg_free[r]);
            m_haz = (id_uses_s && busy(id_srcs))
                 || (id_uses_t && busy(id_srct))
                 || (id_writes && busy(id_dest))
                 || (id_cond_rd && t < cond_free);
            if (draining) begin
                e_st = 1'b1;
                if (t >= halt_at) e_dd = 1'b1;
                else e_bub = 1'b1;
            end else if (t < sq_end || redirect) begin
                e_sq = 1'b1;
                if (redirect) sq_end = t + SLOTS + 1;
            end else if (drain_req) begin
                e_st = 1'b1; e_bub = 1'b1;
                draining = 1'b1;
                halt_at  = t + 2;
                for (int r = 0; r < NR; r++)
                    if (reg_free[r] > halt_at) halt_at = reg_free[r];
                if (cond_free > halt_at) halt_at = cond_free;
            end else if (id_valid && m_haz) begin
                e_st = 1'b1; e_bub = 1'b1;
            end else begin
                e_iss = id_valid;
                if (id_valid && id_writes) begin
                    m_lat = (id_lat == 2'd0) ? 1 : int'(id_lat);
                    reg_free[id_dest] = t + 1 + m_lat;
                end
                if (id_valid && id_cond_wr) cond_free = t + 2;
            end
        end
        chk1("m_issue", issue, e_iss);
        chk1("m_stall", stall, e_st);
        chk1("m_bubble", bubble, e_bub);
        chk1("m_squash", squash, e_sq);
        chk1("m_drain_done", drain_done, e_dd);
        chkv("m_busy_map", busy_map, e_bm);
        t++;
    end

    task automatic idle();
        id_valid = 0; id_srcs = 0; id_uses_s = 0; id_srct = 0;
        id_uses_t = 0; id_dest = 0; id_writes = 0; id_lat = 0;
        id_cond_rd = 0; id_cond_wr = 0; redirect = 0; drain_req = 0;
    endtask

    task automatic wr(input logic [3:0] d, input logic [1:0] lat);
        idle();
        id_valid = 1; id_dest = d; id_writes = 1; id_lat = lat;
    endtask

    task automatic rd(input logic [3:0] s, input logic [3:0] tt,
                      input logic ut);
        idle();
        id_valid = 1; id_srcs = s; id_uses_s = 1;
        id_srct = tt; id_uses_t = ut;
    endtask

    task automatic nextc();
        @(posedge clk);
        #1;
    endtask

    task automatic atneg();
        @(negedge clk);
    endtask

    task automatic rnd(input logic drn);
        id_valid   = ($urandom % 4) != 0;
        id_srcs    = 4'($urandom % 4);
        id_uses_s  = 1'($urandom);
        id_srct    = 4'($urandom % 4);
        id_uses_t  = 1'($urandom);
        id_dest    = 4'($urandom % 4);
        id_writes  = 1'($urandom);
        id_lat     = 2'($urandom);
        id_cond_rd = ($urandom % 5) == 0;
        id_cond_wr = ($urandom % 5) == 0;
        redirect   = ($urandom % 12) == 0;
        drain_req  = drn;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1);
    end

    initial begin
        int ns;
        int w;
        reset = 1'b1;
        idle();
        id_valid = 1;
        #2;
        chk1("rst_issue", issue, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_squash", squash, 1'b0);
        chk1("rst_drain_done", drain_done, 1'b0);
        chkv("rst_busy", busy_map, '0);
        idle();
        nextc();
        reset = 1'b0;

        // RAW on r3
        wr(4'd3, 2'd2);
        atneg(); chk1("t1_issueA", issue, 1'b1);
        nextc(); rd(4'd3, 4'd0, 1'b0);
        atneg(); chk1("t1_stall1", stall, 1'b1);
        chk1("t1_bubble1", bubble, 1'b1);
        chk1("t1_busy3a", busy_map[3], 1'b1);
        nextc();
        atneg(); chk1("t1_stall2", stall, 1'b1);
        chk1("t1_busy3b", busy_map[3], 1'b1);
        nextc();
        atneg(); chk1("t1_issueB", issue, 1'b1);
        chk1("t1_busy3c", busy_map[3], 1'b0);
        nextc(); idle();

        // No false hazard
        wr(4'd3, 2'd2);
        atneg(); nextc(); rd(4'd5, 4'd6, 1'b1);
        atneg(); chk1("t2_issue", issue, 1'b1);
        chk1("t2_stall", stall, 1'b0);
        nextc(); idle();
        repeat (3) nextc();

        // WAW on r7
        wr(4'd7, 2'd3);
        atneg(); nextc(); wr(4'd7, 2'd1);
        ns = 0;
        repeat (3) begin atneg(); ns += int'(stall); nextc(); end
        atneg(); chki("t3_waw_nstall", ns, 3);
        chk1("t3_waw_issue", issue, 1'b1);
        nextc(); idle();
        repeat (2) nextc();

        // co then br
        idle(); id_valid = 1; id_cond_wr = 1;
        atneg(); chk1("t3_co_issue", issue, 1'b1);
        nextc(); idle(); id_valid = 1; id_cond_rd = 1;
        atneg(); chk1("t3_br_stall", stall, 1'b1);
        nextc();
        atneg(); chk1("t3_br_issue", issue, 1'b1);
        nextc(); idle();

        // Redirect coinciding with a hazard
        wr(4'd4, 2'd3);
        atneg(); nextc(); rd(4'd4, 4'd0, 1'b0); redirect = 1;
        atneg(); chk1("t4_sq1", squash, 1'b1);
        chk1("t4_st1", stall, 1'b0);
        chk1("t4_is1", issue, 1'b0);
        nextc(); redirect = 0;
        atneg(); chk1("t4_sq2", squash, 1'b1);
        chk1("t4_st2", stall, 1'b0);
        chk1("t4_is2", issue, 1'b0);
        nextc();
        atneg(); chk1("t4_sq3", squash, 1'b0);
        chk1("t4_st3", stall, 1'b1);
        nextc(); idle();
        repeat (2) nextc();

        // Drain with r2 pending
        wr(4'd2, 2'd3);
        atneg(); chk1("t5_issueA", issue, 1'b1);
        nextc(); idle(); drain_req = 1;
        atneg(); chk1("t5_st1", stall, 1'b1);
        nextc(); redirect = 1;
        atneg(); chk1("t5_st2", stall, 1'b1);
        chk1("t5_nosq", squash, 1'b0);
        chk1("t5_dd2", drain_done, 1'b0);
        nextc(); redirect = 0;
        atneg(); chk1("t5_st3", stall, 1'b1);
        chk1("t5_dd3", drain_done, 1'b0);
        nextc();
        atneg(); chk1("t5_dd4", drain_done, 1'b1);
        nextc();
        atneg(); chk1("t5_dd5", drain_done, 1'b1);
        chk1("t5_st5", stall, 1'b1);
        nextc(); idle(); reset = 1'b1;
        nextc(); reset = 1'b0;

        // Reset between edges while stalled
        wr(4'd9, 2'd3);
        atneg(); nextc(); rd(4'd0, 4'd9, 1'b1);
        atneg(); chk1("t6_stall", stall, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("t6_issue0", issue, 1'b0);
        chk1("t6_stall0", stall, 1'b0);
        chk1("t6_squash0", squash, 1'b0);
        chkv("t6_busy0", busy_map, '0);
        nextc(); atneg(); nextc(); reset = 1'b0;
        atneg(); chk1("t6_issue", issue, 1'b1);
        chk1("t6_nostall", stall, 1'b0);
        nextc(); idle();

        // Random epochs, each ending in a drain and a reset
        for (int ep = 0; ep < 6; ep++) begin
            repeat (120) begin rnd(1'b0); nextc(); end
            w = 0;
            rnd(1'b1);
            forever begin
                atneg();
                if (drain_done || w >= 40) break;
                w++;
                nextc();
                rnd(1'b1);
            end
            if (w >= 40) chk1("drain_timeout", drain_done, 1'b1);
            nextc(); idle(); reset = 1'b1;
            nextc(); reset = 1'b0;
        end

        repeat (2) nextc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
